// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter
//   Round-robin selector controller that drives the 2-bit select of a
//   downstream 4-to-1 nibble mux. A grant is held while its owner streams
//   beats; a per-grant beat limit (HOLD) forces rotation so no source can
//   starve the others. A valid/ready pair lets the consumer stall selection.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   req[3:0]   request per source; bit i corresponds to sel value i
//   out_ready  downstream accepts the current mux output this cycle
//   sel[1:0]   registered mux select
//   gnt[3:0]   registered one-hot grant (1 << sel while out_valid, else 0)
//   out_valid  the mux output selected by sel is valid
//   last       combinational; the current beat, if accepted, ends the grant
module rr_sel_arbiter #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [4:0] CNT_MAX = 5'(HOLD - 1);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       valid_nxt;
  logic [3:0] gnt_nxt;

  logic       accept;
  logic       own_req;
  logic       at_max;
  logic       release_grant;
  logic [1:0] sel_inc;

  // First requesting index scanning start, start+1, ... modulo 4. The loop
  // walks from the farthest offset down so the nearest hit is kept.
  function automatic logic [1:0] pick(input logic [3:0] mask,
                                      input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) pick = idx;
    end
  endfunction

  assign accept  = out_valid & out_ready;
  assign own_req = req[sel];
  assign at_max  = (cnt == CNT_MAX);
  assign sel_inc = sel + 2'd1;

  // Completion (accept & ~own_req) and withdrawal (~accept & ~own_req)
  // together reduce to ~own_req; forced release needs an accepted last beat.
  assign release_grant = ~own_req | (accept & at_max);

  assign last = out_valid & (~own_req | at_max);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = pick(req, ptr);
          cnt_nxt   = 5'd0;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_grant) begin
          // Re-arbitrate immediately from the advanced pointer so there is
          // no bubble between consecutive grants.
          ptr_nxt = sel_inc;
          cnt_nxt = 5'd0;
          if (|req) begin
            sel_nxt   = pick(req, sel_inc);
            valid_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else if (accept && !at_max) begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    gnt_nxt = valid_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sel       <= 2'd0;
      ptr       <= 2'd0;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      gnt       <= 4'b0000;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      out_valid <= valid_nxt;
      gnt       <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter with HOLD=4.
module tb_rr_sel_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
  logic       last;

  int vectors;
  int miscompares;

  logic [1:0] es;
  logic [3:0] eg;
  logic       ev;
  logic       el;

  rr_sel_arbiter #(.HOLD(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({sel, gnt, out_valid, last} !== 8'b0) begin
        miscompares++;
        $display("FAIL reset_held[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected all zero",
                 i, sel, gnt, out_valid, last);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({sel, gnt, out_valid, last} !== 8'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected all zero",
                 i, sel, gnt, out_valid, last);
      end
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      es = 2'd2; eg = 4'b0100; ev = 1'b1; el = ((i % 4) == 3);
      vectors++;
      if ({sel, gnt, out_valid, last} !== {es, eg, ev, el}) begin
        miscompares++;
        $display("FAIL single[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected sel=%0d gnt=%b vld=%b last=%b",
                 i, sel, gnt, out_valid, last, es, eg, ev, el);
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd2, 4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_idle: sel=%0d gnt=%b vld=%b last=%b, expected sel=2 gnt=0000 vld=0 last=0",
               sel, gnt, out_valid, last);
    end
  endtask

  task automatic test_all_requesting();
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      es = 2'((i / 4) % 4);
      eg = 4'b0001 << es;
      ev = 1'b1;
      el = ((i % 4) == 3);
      vectors++;
      if ({sel, gnt, out_valid, last} !== {es, eg, ev, el}) begin
        miscompares++;
        $display("FAIL all_req[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected sel=%0d gnt=%b vld=%b last=%b",
                 i, sel, gnt, out_valid, last, es, eg, ev, el);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req       = 4'b0110;
    out_ready = 1'b1;
    // Grant to source 1, then two accepted beats bring cnt to 2.
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({sel, gnt, out_valid, last} !== {2'd1, 4'b0010, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_pre[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected sel=1 gnt=0010 vld=1 last=0",
                 i, sel, gnt, out_valid, last);
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({sel, gnt, out_valid, last} !== {2'd1, 4'b0010, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected sel=1 gnt=0010 vld=1 last=0",
                 i, sel, gnt, out_valid, last);
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd1, 4'b0010, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_beat3: sel=%0d gnt=%b vld=%b last=%b, expected sel=1 gnt=0010 vld=1 last=1",
               sel, gnt, out_valid, last);
    end
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd2, 4'b0100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_rotate: sel=%0d gnt=%b vld=%b last=%b, expected sel=2 gnt=0100 vld=1 last=0",
               sel, gnt, out_valid, last);
    end
  endtask

  task automatic test_withdraw_complete();
    do_reset();
    req       = 4'b1000;
    out_ready = 1'b1;
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd3, 4'b1000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wd_grant3: sel=%0d gnt=%b vld=%b last=%b, expected sel=3 gnt=1000 vld=1 last=0",
               sel, gnt, out_valid, last);
    end
    // Owner 3 withdraws while the consumer is stalled.
    out_ready = 1'b0;
    req       = 4'b0011;
    #1;
    vectors++;
    if ({sel, out_valid, last} !== {2'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wd_last: sel=%0d vld=%b last=%b, expected sel=3 vld=1 last=1",
               sel, out_valid, last);
    end
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd0, 4'b0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wd_wrap: sel=%0d gnt=%b vld=%b last=%b, expected sel=0 gnt=0001 vld=1 last=0",
               sel, gnt, out_valid, last);
    end
    // Source 0 drops its request on an accepted beat.
    out_ready = 1'b1;
    req       = 4'b0010;
    #1;
    vectors++;
    if ({sel, out_valid, last} !== {2'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL cmp_last: sel=%0d vld=%b last=%b, expected sel=0 vld=1 last=1",
               sel, out_valid, last);
    end
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd1, 4'b0010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL cmp_next: sel=%0d gnt=%b vld=%b last=%b, expected sel=1 gnt=0010 vld=1 last=0",
               sel, gnt, out_valid, last);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd1, 4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL cmp_idle: sel=%0d gnt=%b vld=%b last=%b, expected sel=1 gnt=0000 vld=0 last=0",
               sel, gnt, out_valid, last);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if ({sel, gnt, out_valid, last} !== {2'd2, 4'b0100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_pre: sel=%0d gnt=%b vld=%b last=%b, expected sel=2 gnt=0100 vld=1 last=0",
               sel, gnt, out_valid, last);
    end
    #3;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({sel, gnt, out_valid, last} !== 8'b0) begin
      miscompares++;
      $display("FAIL mid_async: sel=%0d gnt=%b vld=%b last=%b, expected all zero",
               sel, gnt, out_valid, last);
    end
    tick();
    rstn = 1'b1;
    #1;
    vectors++;
    if ({sel, gnt, out_valid, last} !== 8'b0) begin
      miscompares++;
      $display("FAIL mid_released: sel=%0d gnt=%b vld=%b last=%b, expected all zero",
               sel, gnt, out_valid, last);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      es = 2'd2; eg = 4'b0100; ev = 1'b1; el = (i == 3);
      vectors++;
      if ({sel, gnt, out_valid, last} !== {es, eg, ev, el}) begin
        miscompares++;
        $display("FAIL mid_regrant[%0d]: sel=%0d gnt=%b vld=%b last=%b, expected sel=%0d gnt=%b vld=%b last=%b",
                 i, sel, gnt, out_valid, last, es, eg, ev, el);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    req         = 4'b0000;
    out_ready   = 1'b0;
    test_reset();
    test_single_requester();
    test_all_requesting();
    test_stall();
    test_withdraw_complete();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin selector controller that sits directly upstream of the 4-to-1 nibble mux and drives its 2-bit `sel`. It arbitrates four request lines and holds a grant while the owner streams beats through the mux. A per-grant beat limit forces rotation so no source can starve the others. It also presents a valid/ready handshake so the downstream consumer of the mux output can stall the selection.

## Interface
- `HOLD`, default 4: maximum accepted beats per grant before forced rotation. Legal range 1..16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  reset, asynchronous and active-low.
- `req`  input  4  request per source; bit i corresponds to `sel` value i.
- `out_ready`  input  1  downstream accepts the current mux output this cycle.
- `sel`  output  2  registered mux select; connects to the mux `sel`.
- `gnt`  output  4  registered one-hot grant; equals `1 << sel` when `out_valid`, 0 otherwise.
- `out_valid`  output  1  the mux output selected by `sel` is valid.
- `last`  output  1  combinational; high when the current beat, if accepted, ends the grant.

## Operation
- State: `IDLE`, `GRANT`. Registers:
  - `sel[1:0]`
  - `ptr[1:0]`: highest-priority index
  - `cnt[4:0]`: beats accepted in the current grant
  - `out_valid`
- Arbitration function `pick(mask)` returns the first index i with `mask[i]=1`, scanning `ptr`, `ptr+1`, … modulo 4.
- A beat is accepted when `out_valid & out_ready`.
- IDLE:
  - If `req != 0`, register `sel = pick(req)`, `cnt = 0`, `out_valid = 1`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, release conditions (evaluated every cycle):
  - **Completion:** beat accepted and `req[sel]=0` in the same cycle.
  - **Forced:** beat accepted and `cnt == HOLD-1`.
  - **Withdrawal:** `req[sel]=0` and no beat accepted. The in-flight beat is dropped.
- On release:
  - Set `ptr = sel+1` (mod 4).
  - Re-arbitrate in the same cycle using `pick` with the updated pointer over the current `req`.
  - If any request is present: load the new `sel`, set `cnt = 0`, keep `out_valid = 1`, and stay in GRANT. There is no bubble.
  - If no request is present: clear `out_valid` and go to IDLE.
  - The previous owner may be regranted if it is the only requester. Its `cnt` restarts at 0.
- GRANT with no release:
  - If a beat is accepted, `cnt` increments.
  - If no beat is accepted, hold everything.
- `sel` changes only on a release, or on the IDLE→GRANT transition.
- `last = out_valid & (~req[sel] | cnt == HOLD-1)`.
- `cnt` saturates at HOLD-1 and never wraps. `ptr` wraps 3→0.

## Timing
- Reset values: `sel=0`, `gnt=0`, `out_valid=0`, `ptr=0`, `cnt=0`, state IDLE. `last` is 0 because `out_valid=0`.
- Reset asserted mid-grant clears all of the above immediately, without waiting for a clock edge. The first grant after release of `rstn` starts from `ptr=0`.
- Latency:
  - `req` rises at edge N while IDLE → `out_valid` and `sel` are valid after edge N+1.
  - Grant to grant on release: the new `sel` appears on the edge after the releasing cycle. `out_valid` stays high across the change.
- `out_ready` low: `sel`, `cnt`, and `out_valid` are held indefinitely. Only a withdrawal can move `sel`.
- Simultaneous completion and forced release: treated as a single release. `ptr` advances once.
- `HOLD=1`: every accepted beat releases the grant, giving pure round-robin per beat.
- `req` bits of non-owners have no effect until a release.

## Test plan
- **Reset:** drive `rstn=0` for 3 cycles, then release with `req=0` → `sel=0`, `gnt=0`, `out_valid=0` held for 5 cycles.
- **Single requester:** `req=4'b0100`, `out_ready=1`, `HOLD=4` → `out_valid` high from the cycle after `req`. `sel=2` continuously. `last` pulses every 4th beat, and `gnt` stays `4'b0100` across the regrants.
- **All requesting:** `req=4'b1111`, `out_ready=1`, `HOLD=4` → `sel` sequence 0×4, 1×4, 2×4, 3×4, 0…, with no idle cycle between grants.
- **Stall:** during a grant of `sel=1` at `cnt=2`, hold `out_ready=0` for 6 cycles → `sel=1`, `cnt=2`, `out_valid=1` are unchanged. After `out_ready` returns, 2 more beats are accepted, then rotation.
- **Withdrawal and completion:** owner 3 drops `req` while `out_ready=0`, with `req=4'b0011` → next `sel=0` (`ptr` wrapped to 0). Then source 0 drops `req` on an accepted beat → `sel=1`.
- **Reset mid-grant:** assert `rstn=0` asynchronously between edges while `sel=2` and `cnt=1` → outputs go to reset values immediately. After release with `req=4'b0100`, the new grant is `sel=2` with `cnt=0`.
